// File: rtl/io_ring_pkg.sv
// Shared types and default timing for the IO ring power sequencer.
package io_ring_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_WAIT_SUP = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_REL_ISO  = 3'd3,
    ST_ON       = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_ISOLATE  = 3'd6,
    ST_FAULT    = 3'd7
  } io_seq_state_e;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_SETTLE_CYC  = 64;
  localparam int unsigned DEF_ISO_CYC     = 8;
  localparam int unsigned DEF_TIMEOUT_CYC = 4096;
  localparam int unsigned DEF_CNT_W       = 13;

endpackage

// File: rtl/io_sync_bit.sv
// Multi-flop synchronizer for one asynchronous level; resets to 0 (supply not good).
module io_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/io_ring_pwr_seq.sv
// Power sequencer for the 1.8 V IO ring: orders isolation, retention and
// output-enable release/assertion against synchronized supply-good inputs.
module io_ring_pwr_seq
  import io_ring_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int unsigned ISO_CYC     = DEF_ISO_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vddio_ok_i,
  input  logic       vdd_ok_i,
  input  logic       pwr_on_req_i,
  input  logic       fault_clr_i,
  output logic       pad_iso_o,
  output logic       pad_oe_en_o,
  output logic       pad_ret_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ISO_LAST     = CNT_W'(ISO_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic vddio_ok_s, vdd_ok_s, sup_ok;

  io_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_vddio (
    .clk (clk),
    .rst (rst),
    .d   (vddio_ok_i),
    .q   (vddio_ok_s)
  );

  io_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_vdd (
    .clk (clk),
    .rst (rst),
    .d   (vdd_ok_i),
    .q   (vdd_ok_s)
  );

  assign sup_ok = vddio_ok_s & vdd_ok_s;

  io_seq_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             iso_q, iso_d, oe_q, oe_d, ret_q, ret_d;
  logic             ready_q, ready_d, fault_q, fault_d;
  logic             to_fault;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    iso_d    = iso_q;
    oe_d     = oe_q;
    ret_d    = ret_q;
    ready_d  = ready_q;
    fault_d  = fault_q;
    to_fault = 1'b0;

    unique case (state_q)
      ST_OFF: begin
        iso_d   = 1'b1;
        oe_d    = 1'b0;
        ret_d   = 1'b1;
        ready_d = 1'b0;
        if (pwr_on_req_i) begin
          state_d = ST_WAIT_SUP;
          cnt_d   = '0;
        end
      end
      ST_WAIT_SUP: begin
        if (cnt_q == TIMEOUT_LAST) begin
          to_fault = 1'b1;
        end else if (!pwr_on_req_i) begin
          state_d = ST_OFF;
        end else if (sup_ok) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        // a supply dip here only restarts the wait, it is not a fault
        if (!sup_ok) begin
          state_d = ST_WAIT_SUP;
          cnt_d   = '0;
        end else if (!pwr_on_req_i) begin
          state_d = ST_OFF;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_REL_ISO;
          cnt_d   = '0;
          iso_d   = 1'b0;
          ret_d   = 1'b0;
        end
      end
      ST_REL_ISO: begin
        if (!sup_ok) begin
          to_fault = 1'b1;
        end else if (!pwr_on_req_i) begin
          state_d = ST_ISOLATE;
        end else if (cnt_q == ISO_LAST) begin
          state_d = ST_ON;
          oe_d    = 1'b1;
          ready_d = 1'b1;
        end
      end
      ST_ON: begin
        if (!sup_ok) begin
          to_fault = 1'b1;
        end else if (!pwr_on_req_i) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
          oe_d    = 1'b0;
          ready_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (!sup_ok) begin
          to_fault = 1'b1;
        end else if (cnt_q == ISO_LAST) begin
          state_d = ST_ISOLATE;
        end
      end
      ST_ISOLATE: begin
        state_d = ST_OFF;
        iso_d   = 1'b1;
        ret_d   = 1'b1;
      end
      ST_FAULT: begin
        if (fault_clr_i && !pwr_on_req_i) begin
          state_d = ST_OFF;
          fault_d = 1'b0;
        end
      end
    endcase

    // every fault entry clamps the ring on the same edge
    if (to_fault) begin
      state_d = ST_FAULT;
      iso_d   = 1'b1;
      oe_d    = 1'b0;
      ret_d   = 1'b1;
      ready_d = 1'b0;
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      iso_q   <= 1'b1;
      oe_q    <= 1'b0;
      ret_q   <= 1'b1;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iso_q   <= iso_d;
      oe_q    <= oe_d;
      ret_q   <= ret_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  assign pad_iso_o   = iso_q;
  assign pad_oe_en_o = oe_q;
  assign pad_ret_o   = ret_q;
  assign ready_o     = ready_q;
  assign fault_o     = fault_q;
  assign state_o     = state_q;

  a_oe_needs_no_iso: assert property (@(posedge clk) disable iff (rst)
    pad_oe_en_o |-> !pad_iso_o);
  a_iso_oe_not_same_edge: assert property (@(posedge clk) disable iff (rst)
    !($fell(pad_iso_o) && $rose(pad_oe_en_o)));
  a_ret_low_needs_no_iso: assert property (@(posedge clk) disable iff (rst)
    !pad_ret_o |-> !pad_iso_o);

endmodule
